// File: rtl/gen_proto_pkg.sv
// Shared types for the caller/generator handshake: FSM states and the tuple record
// that generator-style responders emit.
package gen_proto_pkg;

  localparam int GEN_WIDTH = 32;
  localparam int GEN_DEPTH = 8;

  typedef enum logic {
    GEN_DONE = 1'b0,
    GEN_EMIT = 1'b1
  } gen_state_e;

  typedef struct packed {
    logic                        last;
    logic signed [GEN_WIDTH-1:0] d1;
    logic signed [GEN_WIDTH-1:0] d0;
  } gen_tuple_t;

endpackage

// File: rtl/gen_fifo_responder_if.sv
// Generator-side handshake plus the tuple load port of gen_fifo_responder.
// master = caller/loader, slave = responder.
interface gen_fifo_responder_if
  import gen_proto_pkg::*;
#(
  parameter int WIDTH = GEN_WIDTH,
  parameter int DEPTH = GEN_DEPTH
);

  localparam int LW = $clog2(DEPTH + 1);

  logic                    _start;
  logic                    _ready;
  logic                    _valid;
  logic                    _done;
  logic signed [WIDTH-1:0] _out0;
  logic signed [WIDTH-1:0] _out1;

  logic                    wr_valid;
  logic                    wr_ready;
  logic signed [WIDTH-1:0] wr_data0;
  logic signed [WIDTH-1:0] wr_data1;
  logic                    wr_last;
  logic [LW-1:0]           level;

  modport master (
    output _start, _ready, wr_valid, wr_data0, wr_data1, wr_last,
    input  _valid, _done, _out0, _out1, wr_ready, level
  );

  modport slave (
    input  _start, _ready, wr_valid, wr_data0, wr_data1, wr_last,
    output _valid, _done, _out0, _out1, wr_ready, level
  );

endinterface

// File: rtl/gen_tuple_fifo.sv
// Synchronous-write FIFO of {last, d1, d0} entries with registered pointers,
// full/empty flags and an occupancy count. Head entry is presented combinationally.
module gen_tuple_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int EW    = 2 * WIDTH + 1,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          _clock,
  input  logic          _reset,
  input  logic          wr_en,
  input  logic [EW-1:0] wr_data,
  input  logic          rd_en,
  output logic [EW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic          wr_ok;
  logic          rd_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];
  assign level   = level_q;

  // NOTE: storage has no reset; only pointers/level define what is valid, so
  // clearing the array would just add reset fan-out.
  always_ff @(posedge _clock) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/gen_fifo_responder.sv
// Buffer-backed generator responder: replays preloaded 2-tuples over the
// _start/_ready/_valid/_done handshake, one stream per _start.
module gen_fifo_responder
  import gen_proto_pkg::*;
#(
  parameter int WIDTH = GEN_WIDTH,
  parameter int DEPTH = GEN_DEPTH
) (
  input  logic                  _clock,
  input  logic                  _reset,
  gen_fifo_responder_if.slave   bus
);

  localparam int LW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic                    last;
    logic signed [WIDTH-1:0] d1;
    logic signed [WIDTH-1:0] d0;
  } entry_t;

  gen_state_e    state;
  entry_t        wr_entry;
  entry_t        head;
  entry_t        out_q;
  logic          valid_q;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic          handshake;
  logic          push;
  logic          pop;

  assign wr_entry  = {bus.wr_last, bus.wr_data1, bus.wr_data0};
  assign handshake = bus._ready && valid_q;
  assign push      = bus.wr_valid && !fifo_full;
  // A last-tuple handshake ends the stream, so nothing behind it is pulled in.
  assign pop       = (state == GEN_EMIT) && !bus._start && !fifo_empty &&
                     (!valid_q || (handshake && !out_q.last));

  gen_tuple_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    ._clock  (_clock),
    ._reset  (_reset),
    .wr_en   (push),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      state   <= GEN_DONE;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      case (state)
        GEN_DONE: begin
          if (bus._start) state <= GEN_EMIT;
        end
        GEN_EMIT: begin
          if (bus._start) begin
            // Restart: drop the held tuple, leave the buffer alone.
            valid_q <= 1'b0;
          end else if (handshake && out_q.last) begin
            state   <= GEN_DONE;
            valid_q <= 1'b0;
          end else if (!valid_q || handshake) begin
            valid_q <= pop;
            if (pop) out_q <= head;
          end
        end
        default: state <= GEN_DONE;
      endcase
    end
  end

  assign bus._valid   = valid_q;
  assign bus._done    = (state == GEN_DONE);
  assign bus._out0    = out_q.d0;
  assign bus._out1    = out_q.d1;
  assign bus.wr_ready = !fifo_full;
  assign bus.level    = fifo_level;

endmodule
